// File: rtl/led_display_monitor_pkg.sv
// Shared definitions for the LED display monitor: FSM states, select-byte
// patterns, segment bit order and the select-byte decoder.
package led_display_monitor_pkg;

   localparam int unsigned FRAME_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SHIFT     = 2'd1,
      ST_WAIT_PEER = 2'd2,
      ST_DECODE    = 2'd3
   } mon_state_e;

   localparam logic [7:0] SEL_D0 = 8'h10;
   localparam logic [7:0] SEL_D1 = 8'h20;
   localparam logic [7:0] SEL_D2 = 8'h40;
   localparam logic [7:0] SEL_D3 = 8'h80;

   // Segment byte layout {a b c d e f g DP}, shared with the display controller.
   typedef enum int unsigned {
      SEG_DP = 0,
      SEG_G  = 1,
      SEG_F  = 2,
      SEG_E  = 3,
      SEG_D  = 4,
      SEG_C  = 5,
      SEG_B  = 6,
      SEG_A  = 7
   } seg_bit_e;

   typedef struct packed {
      logic       valid;
      logic [1:0] digit;
   } sel_decode_t;

   function automatic sel_decode_t decode_select(input logic [7:0] sel);
      sel_decode_t r;
      case (sel)
         SEL_D0:  r = '{valid: 1'b1, digit: 2'd0};
         SEL_D1:  r = '{valid: 1'b1, digit: 2'd1};
         SEL_D2:  r = '{valid: 1'b1, digit: 2'd2};
         SEL_D3:  r = '{valid: 1'b1, digit: 2'd3};
         default: r = '{valid: 1'b0, digit: 2'd0};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_display_monitor_if.sv
// Wire-level bundle of the two 74HC164 serial lines (A = digit select, B = segments).
interface led_display_monitor_if;

   logic shifter_a_ds;
   logic shifter_a_cp;
   logic shifter_a_mr_n;
   logic shifter_b_ds;
   logic shifter_b_cp;
   logic shifter_b_mr_n;

   modport master (
      output shifter_a_ds, shifter_a_cp, shifter_a_mr_n,
      output shifter_b_ds, shifter_b_cp, shifter_b_mr_n
   );

   modport slave (
      input shifter_a_ds, shifter_a_cp, shifter_a_mr_n,
      input shifter_b_ds, shifter_b_cp, shifter_b_mr_n
   );

endinterface

// File: rtl/led_display_monitor_hc164_rx_channel.sv
// One 74HC164 receive channel: input synchronizers, cp rise detection,
// ds re-inversion, 8-bit shift register with bit counter, done flag and mr_n clear.
module led_display_monitor_hc164_rx_channel
   import led_display_monitor_pkg::*;
#(
   parameter logic        COMMON_ANODE = 1'b1,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ds_i,
   input  logic       cp_i,
   input  logic       mr_n_i,
   input  logic       clr_i,
   output logic [7:0] sr_o,
   output logic       rise_o,
   output logic       fin_o,
   output logic       done_o,
   output logic       ovr_o,
   output logic       mr_o
);

   logic [SYNC_STAGES-1:0] ds_sync_q;
   logic [SYNC_STAGES-1:0] cp_sync_q;
   logic [SYNC_STAGES-1:0] mr_n_sync_q;
   logic                   cp_prev_q;
   logic [7:0]             sr_q, sr_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic                   ds_s, cp_s, mr_s, rise_s, fin_s;

   // Synchronizer chains and previous-cp flop for edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ds_sync_q   <= '0;
         cp_sync_q   <= '0;
         mr_n_sync_q <= '0;
         cp_prev_q   <= 1'b0;
      end else begin
         ds_sync_q   <= {ds_sync_q[SYNC_STAGES-2:0], ds_i};
         cp_sync_q   <= {cp_sync_q[SYNC_STAGES-2:0], cp_i};
         mr_n_sync_q <= {mr_n_sync_q[SYNC_STAGES-2:0], mr_n_i};
         cp_prev_q   <= cp_sync_q[SYNC_STAGES-1];
      end
   end

   assign ds_s   = ds_sync_q[SYNC_STAGES-1] ^ COMMON_ANODE;
   assign cp_s   = cp_sync_q[SYNC_STAGES-1];
   assign mr_s   = ~mr_n_sync_q[SYNC_STAGES-1];
   assign rise_s = cp_s & ~cp_prev_q;
   assign fin_s  = rise_s & ~done_q & (cnt_q == 4'(FRAME_BITS - 1));

   // Shift register / counter next state; a rise on a done channel is not shifted.
   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      done_d = done_q;
      if (mr_s || clr_i) begin
         sr_d   = 8'h00;
         cnt_d  = 4'd0;
         done_d = 1'b0;
      end else if (rise_s && !done_q) begin
         sr_d   = {sr_q[6:0], ds_s};
         cnt_d  = cnt_q + 4'd1;
         done_d = fin_s;
      end else begin
         sr_d   = sr_q;
         cnt_d  = cnt_q;
         done_d = done_q;
      end
   end

   // Shift register state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q   <= 8'h00;
         cnt_q  <= 4'd0;
         done_q <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign sr_o   = sr_q;
   assign rise_o = rise_s;
   assign fin_o  = fin_s;
   assign done_o = done_q;
   assign ovr_o  = rise_s & done_q;
   assign mr_o   = mr_s;

endmodule

// File: rtl/led_display_monitor.sv
// Receive-side LED display monitor: deserializes select/segment frames from two
// 74HC164 lines, validates the select byte and stores the segment byte per digit.
module led_display_monitor
   import led_display_monitor_pkg::*;
#(
   parameter logic        COMMON_ANODE  = 1'b1,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned IDLE_TIMEOUT  = 64,
   parameter int unsigned SKEW_MAX      = 8,
   parameter int unsigned TIMEOUT_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   led_display_monitor_if.slave    wire_i,
   output logic [7:0]              o_digit_D0,
   output logic [7:0]              o_digit_D1,
   output logic [7:0]              o_digit_D2,
   output logic [7:0]              o_digit_D3,
   output logic [3:0]              o_digit_seen,
   output logic                    o_frame_stb,
   output logic [1:0]              o_frame_digit,
   output logic                    o_err_select,
   output logic                    o_err_frame,
   output logic [7:0]              o_err_count
);

   logic [7:0] sr_a_s, sr_b_s;
   logic       rise_a_s, rise_b_s, fin_a_s, fin_b_s, done_a_s, done_b_s;
   logic       ovr_a_s, ovr_b_s, mr_a_s, mr_b_s;
   logic       chan_clr_s;

   led_display_monitor_hc164_rx_channel #(
      .COMMON_ANODE (COMMON_ANODE),
      .SYNC_STAGES  (SYNC_STAGES)
   ) u_chan_a (
      .clk_i  (i_clk),
      .rst_i  (i_reset),
      .ds_i   (wire_i.shifter_a_ds),
      .cp_i   (wire_i.shifter_a_cp),
      .mr_n_i (wire_i.shifter_a_mr_n),
      .clr_i  (chan_clr_s),
      .sr_o   (sr_a_s),
      .rise_o (rise_a_s),
      .fin_o  (fin_a_s),
      .done_o (done_a_s),
      .ovr_o  (ovr_a_s),
      .mr_o   (mr_a_s)
   );

   led_display_monitor_hc164_rx_channel #(
      .COMMON_ANODE (COMMON_ANODE),
      .SYNC_STAGES  (SYNC_STAGES)
   ) u_chan_b (
      .clk_i  (i_clk),
      .rst_i  (i_reset),
      .ds_i   (wire_i.shifter_b_ds),
      .cp_i   (wire_i.shifter_b_cp),
      .mr_n_i (wire_i.shifter_b_mr_n),
      .clr_i  (chan_clr_s),
      .sr_o   (sr_b_s),
      .rise_o (rise_b_s),
      .fin_o  (fin_b_s),
      .done_o (done_b_s),
      .ovr_o  (ovr_b_s),
      .mr_o   (mr_b_s)
   );

   mon_state_e               state_q;
   logic [TIMEOUT_WIDTH-1:0] idle_cnt_q;
   logic [TIMEOUT_WIDTH-1:0] skew_cnt_q;
   logic [3:0][7:0]          digit_q;
   logic [3:0]               seen_q;
   logic                     frame_stb_q;
   logic [1:0]               frame_digit_q;
   logic                     err_select_q;
   logic                     err_frame_q;
   logic [7:0]               err_count_q;

   sel_decode_t sel_s;
   logic        a_now_s, b_now_s, any_rise_s, active_s;
   logic        idle_to_s, skew_to_s, abort_s, decode_s, err_evt_s;

   // "now" includes a channel finishing this very cycle, so DECODE follows the final rise directly.
   assign sel_s      = decode_select(sr_a_s);
   assign a_now_s    = done_a_s | fin_a_s;
   assign b_now_s    = done_b_s | fin_b_s;
   assign any_rise_s = rise_a_s | rise_b_s;
   assign active_s   = (state_q == ST_SHIFT) || (state_q == ST_WAIT_PEER);
   assign decode_s   = (state_q == ST_DECODE);
   assign idle_to_s  = active_s && !any_rise_s &&
                       (idle_cnt_q == TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1));
   assign skew_to_s  = (state_q == ST_WAIT_PEER) && !(a_now_s && b_now_s) &&
                       (skew_cnt_q == TIMEOUT_WIDTH'(SKEW_MAX - 1));
   assign abort_s    = active_s &&
                       (mr_a_s || mr_b_s || ovr_a_s || ovr_b_s || idle_to_s || skew_to_s);
   assign chan_clr_s = abort_s || decode_s;
   assign err_evt_s  = abort_s || (decode_s && !sel_s.valid);

   // Idle (no rise) and peer-skew timers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         idle_cnt_q <= '0;
         skew_cnt_q <= '0;
      end else begin
         if (!active_s || any_rise_s) begin
            idle_cnt_q <= '0;
         end else begin
            idle_cnt_q <= idle_cnt_q + TIMEOUT_WIDTH'(1);
         end
         if (state_q == ST_WAIT_PEER) begin
            skew_cnt_q <= skew_cnt_q + TIMEOUT_WIDTH'(1);
         end else begin
            skew_cnt_q <= '0;
         end
      end
   end

   // Frame FSM with registered digit storage, strobes and error counter.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= ST_IDLE;
         digit_q       <= '0;
         seen_q        <= 4'h0;
         frame_stb_q   <= 1'b0;
         frame_digit_q <= 2'd0;
         err_select_q  <= 1'b0;
         err_frame_q   <= 1'b0;
         err_count_q   <= 8'h00;
      end else begin
         frame_stb_q  <= 1'b0;
         err_select_q <= 1'b0;
         err_frame_q  <= abort_s;
         case (state_q)
            ST_IDLE: begin
               if (any_rise_s) begin
                  state_q <= ST_SHIFT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (abort_s) begin
                  state_q <= ST_IDLE;
               end else if (a_now_s && b_now_s) begin
                  state_q <= ST_DECODE;
               end else if (a_now_s || b_now_s) begin
                  state_q <= ST_WAIT_PEER;
               end else begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_WAIT_PEER: begin
               if (abort_s) begin
                  state_q <= ST_IDLE;
               end else if (a_now_s && b_now_s) begin
                  state_q <= ST_DECODE;
               end else begin
                  state_q <= ST_WAIT_PEER;
               end
            end
            ST_DECODE: begin
               state_q <= ST_IDLE;
               if (sel_s.valid) begin
                  digit_q[sel_s.digit] <= sr_b_s;
                  seen_q[sel_s.digit]  <= 1'b1;
                  frame_stb_q          <= 1'b1;
                  frame_digit_q        <= sel_s.digit;
               end else begin
                  err_select_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
         if (err_evt_s && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   assign o_digit_D0    = digit_q[0];
   assign o_digit_D1    = digit_q[1];
   assign o_digit_D2    = digit_q[2];
   assign o_digit_D3    = digit_q[3];
   assign o_digit_seen  = seen_q;
   assign o_frame_stb   = frame_stb_q;
   assign o_frame_digit = frame_digit_q;
   assign o_err_select  = err_select_q;
   assign o_err_frame   = err_frame_q;
   assign o_err_count   = err_count_q;

endmodule

// File: tb/tb_led_display_monitor.sv
// Directed + randomized bench for led_display_monitor; expectations come from a
// frame-level model of the display contents, seen mask and error count.
module tb_led_display_monitor;

   localparam logic CA = 1'b1;

   logic       clk;
   logic       i_reset;
   logic [7:0] d0, d1, d2, d3;
   logic [3:0] seen;
   logic       frame_stb;
   logic [1:0] frame_digit;
   logic       err_select;
   logic       err_frame;
   logic [7:0] err_count;

   led_display_monitor_if bus ();

   led_display_monitor #(
      .COMMON_ANODE  (CA),
      .SYNC_STAGES   (2),
      .IDLE_TIMEOUT  (64),
      .SKEW_MAX      (8),
      .TIMEOUT_WIDTH (8)
   ) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .wire_i        (bus),
      .o_digit_D0    (d0),
      .o_digit_D1    (d1),
      .o_digit_D2    (d2),
      .o_digit_D3    (d3),
      .o_digit_seen  (seen),
      .o_frame_stb   (frame_stb),
      .o_frame_digit (frame_digit),
      .o_err_select  (err_select),
      .o_err_frame   (err_frame),
      .o_err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Output event monitor
   int stb_q[$];
   int n_sel = 0;
   int n_frm = 0;
   always @(negedge clk) begin
      if (frame_stb) stb_q.push_back(int'(frame_digit));
      if (err_select) n_sel <= n_sel + 1;
      if (err_frame) n_frm <= n_frm + 1;
   end

   // Reference model state
   logic [7:0] m_digit [4];
   logic [3:0] m_seen;
   int         m_cnt;
   int         base_sel, base_frm;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_digit[k] = 8'h00;
      m_seen = 4'h0;
      m_cnt  = 0;
   endtask

   task automatic model_error();
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
   endtask

   task automatic snapshot();
      stb_q.delete();
      base_sel = n_sel;
      base_frm = n_frm;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "/D0"}, d0, m_digit[0]);
      chk({tag, "/D1"}, d1, m_digit[1]);
      chk({tag, "/D2"}, d2, m_digit[2]);
      chk({tag, "/D3"}, d3, m_digit[3]);
      chk({tag, "/seen"}, seen, m_seen);
      chk({tag, "/err_count"}, err_count, m_cnt);
   endtask

   task automatic check_events(input string tag, input int exp_stb, input int exp_d,
                               input int exp_sel, input int exp_frm);
      chk({tag, "/stb_count"}, stb_q.size(), exp_stb);
      if (exp_stb == 1 && stb_q.size() >= 1) chk({tag, "/stb_digit"}, stb_q[0], exp_d);
      chk({tag, "/err_sel_pulses"}, n_sel - base_sel, exp_sel);
      chk({tag, "/err_frame_pulses"}, n_frm - base_frm, exp_frm);
   endtask

   // Drive one frame on the wire, MSB first; a channel stops after its bit count.
   task automatic drive_frame(input logic [7:0] a, input logic [7:0] b, input int a_bits,
                              input int b_bits, input int hp, input int lag);
      for (int i = 0; i < 8; i++) begin
         if (i >= a_bits && i >= b_bits) break;
         @(negedge clk);
         if (i < a_bits) bus.shifter_a_ds = a[7-i] ^ CA;
         if (i < b_bits) bus.shifter_b_ds = b[7-i] ^ CA;
         bus.shifter_a_cp = 1'b0;
         bus.shifter_b_cp = 1'b0;
         repeat (hp) @(negedge clk);
         if (i < a_bits) bus.shifter_a_cp = 1'b1;
         repeat (lag) @(negedge clk);
         if (i < b_bits) bus.shifter_b_cp = 1'b1;
         repeat (hp) @(negedge clk);
      end
      bus.shifter_a_cp = 1'b0;
      bus.shifter_b_cp = 1'b0;
   endtask

   // Complete frame, then judge it against the select-byte rule.
   task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input int hp, input int lag);
      bit ok;
      int d;
      snapshot();
      drive_frame(a, b, 8, 8, hp, lag);
      repeat (100) @(negedge clk);
      ok = (a[3:0] == 4'h0) && ($countones(a[7:4]) == 1);
      d  = 0;
      if (ok) begin
         for (int k = 0; k < 4; k++) if (a[4+k]) d = k;
         m_digit[d] = b;
         m_seen[d]  = 1'b1;
      end else begin
         model_error();
      end
      check_events(tag, ok ? 1 : 0, d, ok ? 0 : 1, 0);
      check_regs(tag);
   endtask

   initial begin
      logic [7:0] sel, seg;
      int hp, lag;
      int err_base;

      i_reset = 1'b1;
      bus.shifter_a_ds = 1'b0; bus.shifter_a_cp = 1'b0; bus.shifter_a_mr_n = 1'b1;
      bus.shifter_b_ds = 1'b0; bus.shifter_b_cp = 1'b0; bus.shifter_b_mr_n = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check_regs("reset");
      chk("reset/stb", frame_stb, 1'b0);
      chk("reset/err_frame", err_frame, 1'b0);
      chk("reset/err_select", err_select, 1'b0);
      i_reset = 1'b0;
      repeat (5) @(negedge clk);

      run_frame("basic_d2", 8'h40, 8'hA5, 4, 0);

      run_frame("b2b_d3", 8'h80, 8'h11, 4, 0);
      run_frame("b2b_d2", 8'h40, 8'h22, 4, 0);
      run_frame("b2b_d1", 8'h20, 8'h33, 4, 0);
      run_frame("b2b_d0", 8'h10, 8'h44, 4, 0);

      run_frame("bad_sel_50", 8'h50, 8'hEE, 3, 0);

      // B stalls after five bits: skew abort, then a clean frame
      snapshot();
      drive_frame(8'h10, 8'h99, 8, 5, 4, 0);
      repeat (100) @(negedge clk);
      model_error();
      check_events("skew", 0, 0, 0, 1);
      check_regs("skew");
      run_frame("after_skew", 8'h20, 8'h5C, 4, 2);

      // mr_n pulse mid-frame
      snapshot();
      drive_frame(8'h40, 8'h77, 3, 3, 4, 0);
      @(negedge clk);
      bus.shifter_a_mr_n = 1'b0;
      bus.shifter_b_mr_n = 1'b0;
      repeat (4) @(negedge clk);
      bus.shifter_a_mr_n = 1'b1;
      bus.shifter_b_mr_n = 1'b1;
      repeat (20) @(negedge clk);
      model_error();
      check_events("mr_abort", 0, 0, 0, 1);
      check_regs("mr_abort");
      run_frame("after_mr", 8'h40, 8'h3C, 4, 0);

      // Randomized frames, mostly valid selects, with random cp rate and A/B lag
      for (int n = 0; n < 16; n++) begin
         if ($urandom_range(0, 3) != 0) sel = 8'h10 << $urandom_range(0, 3);
         else sel = 8'($urandom);
         seg = 8'($urandom);
         hp  = $urandom_range(2, 5);
         lag = $urandom_range(0, hp - 1);
         run_frame($sformatf("rand%0d", n), sel, seg, hp, lag);
      end

      // Reset mid-frame
      drive_frame(8'h80, 8'h5A, 4, 4, 3, 0);
      @(negedge clk);
      i_reset = 1'b1;
      #1;
      model_reset();
      check_regs("midreset");
      chk("midreset/stb", frame_stb, 1'b0);
      chk("midreset/err_frame", err_frame, 1'b0);
      @(negedge clk);
      i_reset = 1'b0;
      snapshot();
      repeat (100) @(negedge clk);
      check_events("post_reset", 0, 0, 0, 0);
      check_regs("post_reset");

      // 300 one-bit aborts saturate the error counter
      snapshot();
      err_base = n_frm;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         bus.shifter_a_cp = 1'b1;
         repeat (4) @(negedge clk);
         bus.shifter_a_mr_n = 1'b0;
         repeat (3) @(negedge clk);
         bus.shifter_a_mr_n = 1'b1;
         bus.shifter_a_cp = 1'b0;
         repeat (4) @(negedge clk);
         model_error();
      end
      repeat (10) @(negedge clk);
      chk("saturate/pulses", n_frm - err_base, 300);
      chk("saturate/stb_count", stb_q.size(), 0);
      check_regs("saturate");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
